arp_requester: RTL and testbench

ARP initiator for the TX clock domain. On a resolve request for a target IPv4 address, it transmits a broadcast ARP request frame as a byte stream toward the Ethernet MAC / TX mux. It then waits for a matching ARP reply, supplied as already-parsed fields from the RX path after CDC. It retries on timeout and reports either the resolved MAC or a failure.

---
 rtl/arp_requester.sv | 176 +++++++++++++++++
 tb/tb_arp_requester.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_requester.sv
// ARP requester (initiator) for the TX clock domain.
//
// On a resolve request it sends a 42-byte broadcast ARP request toward the MAC as a
// valid/ack byte stream. It then waits for a parsed ARP reply from the RX path whose
// sender protocol address matches the target. If no reply comes before the timeout it
// retransmits the same frame, up to MAX_RETRIES times, and then reports failure.
//
// Ports:
//   clk, rst            single clock; synchronous active-high reset
//   hw_addr_i           own MAC (ETH src, ARP SHA), latched on request accept
//   ip_addr_i           own IPv4 (ARP SPA), latched on request accept
//   req_i, req_ip_i     one-cycle resolve strobe and target IPv4; accepted only when idle
//   busy_o              high while a resolution is in progress
//   done_o, fail_o      one-cycle result pulses
//   resolved_mac_o      MAC from the last successful resolution
//   rx_reply_valid_i    one-cycle strobe for a parsed ARP reply
//   rx_reply_sha_i      reply sender hardware address
//   rx_reply_spa_i      reply sender protocol address
//   mac_data_o          TX byte
//   mac_valid_o         TX byte valid
//   mac_ack_i           MAC accepts the current byte this cycle
module arp_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] hw_addr_i,
  input  logic [31:0] ip_addr_i,
  input  logic        req_i,
  input  logic [31:0] req_ip_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic [47:0] resolved_mac_o,
  input  logic        rx_reply_valid_i,
  input  logic [47:0] rx_reply_sha_i,
  input  logic [31:0] rx_reply_spa_i,
  output logic [7:0]  mac_data_o,
  output logic        mac_valid_o,
  input  logic        mac_ack_i
);

  localparam int unsigned TmoW = ($clog2(TIMEOUT_CYCLES) > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned AttW = ($clog2(MAX_RETRIES + 1) > 1) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [AttW-1:0] AttMax  = AttW'(MAX_RETRIES);
  localparam logic [5:0]      LastIdx = 6'd41;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait
  } state_e;

  state_e          state_q;
  logic [47:0]     hw_q;
  logic [31:0]     ip_q;
  logic [31:0]     tgt_q;
  logic [AttW-1:0] attempt_q;
  logic [TmoW-1:0] tmo_q;
  logic [5:0]      byte_idx_q;

  logic [335:0]    frame_vec;
  logic [5:0]      idx_nxt;
  logic [8:0]      bit_base;
  logic [7:0]      byte_nxt;
  logic            reply_match;

  // Whole frame as one vector, byte 0 in the top bits; built from latched fields only so
  // input changes during a resolution cannot leak into a (re)transmission.
  always_comb begin
    frame_vec = {48'hffff_ffff_ffff,  // ETH dst: broadcast
                 hw_q,                // ETH src
                 16'h0806,            // ethertype ARP
                 16'h0001,            // htype Ethernet
                 16'h0800,            // ptype IPv4
                 8'h06, 8'h04,        // hlen, plen
                 16'h0001,            // oper request
                 hw_q,                // SHA
                 ip_q,                // SPA
                 48'h0,               // THA
                 tgt_q};              // TPA
    idx_nxt  = byte_idx_q + 6'd1;
    bit_base = {LastIdx - idx_nxt, 3'b000};
    byte_nxt = frame_vec[bit_base +: 8];
  end

  assign reply_match = rx_reply_valid_i && (rx_reply_spa_i == tgt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      hw_q           <= '0;
      ip_q           <= '0;
      tgt_q          <= '0;
      attempt_q      <= '0;
      tmo_q          <= '0;
      byte_idx_q     <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      fail_o         <= 1'b0;
      resolved_mac_o <= '0;
      mac_data_o     <= '0;
      mac_valid_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      fail_o <= 1'b0;

      case (state_q)
        StIdle: begin
          if (req_i) begin
            tgt_q       <= req_ip_i;
            hw_q        <= hw_addr_i;
            ip_q        <= ip_addr_i;
            attempt_q   <= '0;
            byte_idx_q  <= '0;
            // Byte 0 is always broadcast FF, so it can be presented without the latched
            // fields, giving first valid byte one cycle after the request.
            mac_data_o  <= 8'hff;
            mac_valid_o <= 1'b1;
            busy_o      <= 1'b1;
            state_q     <= StSend;
          end
        end

        StSend: begin
          // mac_valid_o is always high here, so ack alone marks a transfer.
          if (mac_ack_i) begin
            if (byte_idx_q == LastIdx) begin
              mac_valid_o <= 1'b0;
              mac_data_o  <= '0;
              tmo_q       <= '0;
              state_q     <= StWait;
            end else begin
              byte_idx_q <= idx_nxt;
              mac_data_o <= byte_nxt;
            end
          end
        end

        StWait: begin
          // A match is checked before the timeout so it wins when both happen together.
          if (reply_match) begin
            resolved_mac_o <= rx_reply_sha_i;
            done_o         <= 1'b1;
            busy_o         <= 1'b0;
            state_q        <= StIdle;
          end else if (tmo_q == TmoLast) begin
            if (attempt_q < AttMax) begin
              attempt_q   <= attempt_q + AttW'(1);
              byte_idx_q  <= '0;
              mac_data_o  <= 8'hff;
              mac_valid_o <= 1'b1;
              state_q     <= StSend;
            end else begin
              fail_o  <= 1'b1;
              busy_o  <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end

        default: begin
          state_q     <= StIdle;
          busy_o      <= 1'b0;
          mac_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arp_requester.sv
// Directed bench for arp_requester. Two instances share all inputs: u_dut_a has a long
// timeout (frame, backpressure, resolution, reset tests) and u_dut_b has
// TIMEOUT_CYCLES=16 / MAX_RETRIES=2 (retry, fail and match-on-timeout tests).
// Inputs are driven and outputs sampled on the falling edge.
module tb_arp_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] hw_addr;
  logic [31:0] ip_addr;
  logic        req;
  logic [31:0] req_ip;
  logic        rx_valid;
  logic [47:0] rx_sha;
  logic [31:0] rx_spa;
  logic        mac_ack;

  logic        busy_a, done_a, fail_a, mac_valid_a;
  logic [47:0] resolved_a;
  logic [7:0]  mac_data_a;
  logic        busy_b, done_b, fail_b, mac_valid_b;
  logic [47:0] resolved_b;
  logic [7:0]  mac_data_b;

  always #5 clk = ~clk;

  arp_requester #(
    .TIMEOUT_CYCLES(200),
    .MAX_RETRIES   (3)
  ) u_dut_a (
    .clk             (clk),
    .rst             (rst),
    .hw_addr_i       (hw_addr),
    .ip_addr_i       (ip_addr),
    .req_i           (req),
    .req_ip_i        (req_ip),
    .busy_o          (busy_a),
    .done_o          (done_a),
    .fail_o          (fail_a),
    .resolved_mac_o  (resolved_a),
    .rx_reply_valid_i(rx_valid),
    .rx_reply_sha_i  (rx_sha),
    .rx_reply_spa_i  (rx_spa),
    .mac_data_o      (mac_data_a),
    .mac_valid_o     (mac_valid_a),
    .mac_ack_i       (mac_ack)
  );

  arp_requester #(
    .TIMEOUT_CYCLES(16),
    .MAX_RETRIES   (2)
  ) u_dut_b (
    .clk             (clk),
    .rst             (rst),
    .hw_addr_i       (hw_addr),
    .ip_addr_i       (ip_addr),
    .req_i           (req),
    .req_ip_i        (req_ip),
    .busy_o          (busy_b),
    .done_o          (done_b),
    .fail_o          (fail_b),
    .resolved_mac_o  (resolved_b),
    .rx_reply_valid_i(rx_valid),
    .rx_reply_sha_i  (rx_sha),
    .rx_reply_spa_i  (rx_spa),
    .mac_data_o      (mac_data_b),
    .mac_valid_o     (mac_valid_b),
    .mac_ack_i       (mac_ack)
  );

  // Hand-written request frame for hw=02:00:00:00:00:01, ip=C0A8010A, target C0A80114.
  localparam logic [335:0] ExpFrame = {48'hffff_ffff_ffff, 48'h0200_0000_0001, 16'h0806,
                                       16'h0001, 16'h0800, 16'h0604, 16'h0001,
                                       48'h0200_0000_0001, 32'hc0a8_010a, 48'h0,
                                       32'hc0a8_0114};

  // Selects which instance the frame collector observes.
  logic       sel_b;
  logic       obs_valid, obs_busy;
  logic [7:0] obs_data;
  assign obs_valid = sel_b ? mac_valid_b : mac_valid_a;
  assign obs_data  = sel_b ? mac_data_b  : mac_data_a;
  assign obs_busy  = sel_b ? busy_b      : busy_a;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [335:0] got, input logic [335:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    req = 1'b0;
    mac_ack = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called on a falling edge; returns on the falling edge where byte 0 should be visible.
  task automatic start_req(input string tag, input logic [31:0] ip);
    req    = 1'b1;
    req_ip = ip;
    @(negedge clk);
    req = 1'b0;
    check({tag, "_lat_valid"}, obs_valid, 1'b1);
    check({tag, "_lat_data"}, obs_data, 8'hff);
    check({tag, "_lat_busy"}, obs_busy, 1'b1);
  endtask

  // Gathers one frame. bp selects ack pattern 1,0,0,...; at cycle req_at a stray request
  // is raised and the own-address inputs are changed.
  task automatic collect(input string tag, input bit bp, input int req_at,
                         output logic [335:0] frame, output int vcyc);
    int         idx = 0;
    int         cyc = 0;
    bit         pend = 1'b0;
    bit         contig = 1'b1;
    bit         hold_ok = 1'b1;
    logic [7:0] held = '0;
    frame = '0;
    vcyc  = 0;
    while (idx < 42 && cyc < 500) begin
      mac_ack = bp ? (cyc % 3 == 0) : 1'b1;
      if (req_at >= 0 && cyc == req_at) begin
        req     = 1'b1;
        req_ip  = 32'hc0a8_0199;
        hw_addr = 48'h0a0b_0c0d_0e0f;
        ip_addr = 32'h0102_0304;
      end else begin
        req = 1'b0;
      end
      if (obs_valid) vcyc++;
      else contig = 1'b0;
      if (pend && obs_data !== held) hold_ok = 1'b0;
      if (obs_valid && mac_ack) begin
        frame = {frame[327:0], obs_data};
        idx++;
        pend = 1'b0;
      end else if (obs_valid) begin
        pend = 1'b1;
        held = obs_data;
      end
      cyc++;
      @(negedge clk);
    end
    mac_ack = 1'b1;
    req     = 1'b0;
    check({tag, "_len"}, idx, 42);
    check({tag, "_contig"}, contig, 1'b1);
    check({tag, "_hold"}, hold_ok, 1'b1);
    check({tag, "_valid_end"}, obs_valid, 1'b0);
  endtask

  logic [335:0] fr;
  int           vc, wc, frames, fl, dn;
  bit           prev_v;

  initial begin
    hw_addr  = 48'h0200_0000_0001;
    ip_addr  = 32'hc0a8_010a;
    req_ip   = '0;
    rx_sha   = '0;
    rx_spa   = '0;
    sel_b    = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_busy", {busy_a, busy_b}, 2'b00);
    check("rst_done_fail", {done_a, fail_a, done_b, fail_b}, 4'b0000);
    check("rst_resolved", resolved_a, 48'h0);
    check("rst_valid", {mac_valid_a, mac_valid_b}, 2'b00);
    check("rst_data", mac_data_a, 8'h00);

    // 1: basic frame with ack held high
    start_req("t1", 32'hc0a8_0114);
    collect("t1", 1'b0, -1, fr, vc);
    check("t1_frame", fr, ExpFrame);
    check("t1_vcycles", vc, 42);

    // 3: non-matching then matching reply while waiting (now WAIT cycle 0)
    repeat (50) @(negedge clk);
    rx_valid = 1'b1;
    rx_spa   = 32'hc0a8_0115;
    rx_sha   = 48'haabb_ccdd_eeff;
    @(negedge clk);
    rx_valid = 1'b0;
    check("t3_nomatch_done", done_a, 1'b0);
    check("t3_nomatch_busy", busy_a, 1'b1);
    repeat (49) @(negedge clk);
    rx_valid = 1'b1;
    rx_spa   = 32'hc0a8_0114;
    @(negedge clk);
    rx_valid = 1'b0;
    check("t3_done", done_a, 1'b1);
    check("t3_busy", busy_a, 1'b0);
    check("t3_resolved", resolved_a, 48'haabb_ccdd_eeff);
    @(negedge clk);
    check("t3_done_pulse", {done_a, fail_a}, 2'b00);

    // 2: backpressure gives the same bytes
    do_reset();
    start_req("t2", 32'hc0a8_0114);
    collect("t2", 1'b1, -1, fr, vc);
    check("t2_frame", fr, ExpFrame);

    // 5b: request and address changes during SEND are ignored
    do_reset();
    start_req("t5b", 32'hc0a8_0114);
    collect("t5b", 1'b0, 5, fr, vc);
    check("t5b_frame", fr, ExpFrame);
    vc = 0;
    repeat (50) begin
      if (mac_valid_a) vc++;
      @(negedge clk);
    end
    check("t5b_no_second", vc, 0);
    check("t5b_busy", busy_a, 1'b1);
    hw_addr = 48'h0200_0000_0001;
    ip_addr = 32'hc0a8_010a;

    // 6: reset at byte 20, then a fresh full frame
    do_reset();
    start_req("t6", 32'hc0a8_0114);
    repeat (20) @(negedge clk);
    check("t6_byte20", {mac_valid_a, mac_data_a}, 9'h100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_valid", mac_valid_a, 1'b0);
    check("t6_busy", busy_a, 1'b0);
    check("t6_pulses", {done_a, fail_a}, 2'b00);
    @(negedge clk);
    start_req("t6b", 32'hc0a8_0114);
    collect("t6b", 1'b0, -1, fr, vc);
    check("t6_frame", fr, ExpFrame);

    // 4: retry/fail on the short-timeout instance, after a first successful resolution
    do_reset();
    sel_b = 1'b1;
    start_req("t4a", 32'hc0a8_0114);
    collect("t4a", 1'b0, -1, fr, vc);
    check("t4a_frame", fr, ExpFrame);
    repeat (5) @(negedge clk);
    rx_valid = 1'b1;
    rx_spa   = 32'hc0a8_0114;
    rx_sha   = 48'h1122_3344_5566;
    @(negedge clk);
    rx_valid = 1'b0;
    check("t4a_done", done_b, 1'b1);
    check("t4a_resolved", resolved_b, 48'h1122_3344_5566);
    @(negedge clk);
    start_req("t4", 32'hc0a8_0114);
    frames = 0; vc = 0; wc = 0; fl = 0; dn = 0; prev_v = 1'b0;
    for (int cyc = 0; cyc < 1000 && !(fl > 0 && cyc > 400); cyc++) begin
      if (mac_valid_b && !prev_v) frames++;
      if (mac_valid_b) vc++;
      if (busy_b && !mac_valid_b) wc++;
      if (done_b) dn++;
      if (fail_b) begin
        fl++;
        check("t4_fail_busy", busy_b, 1'b0);
      end
      prev_v = mac_valid_b;
      @(negedge clk);
    end
    check("t4_frames", frames, 3);
    check("t4_vcycles", vc, 126);
    check("t4_wait_cycles", wc, 48);
    check("t4_fail_pulses", fl, 1);
    check("t4_done_pulses", dn, 0);
    check("t4_resolved", resolved_b, 48'h1122_3344_5566);

    // 5a: match in the same cycle as the final WAIT count
    do_reset();
    start_req("t5a", 32'hc0a8_0114);
    collect("t5a", 1'b0, -1, fr, vc);
    repeat (15) @(negedge clk);
    rx_valid = 1'b1;
    rx_spa   = 32'hc0a8_0114;
    rx_sha   = 48'h0102_0304_0506;
    @(negedge clk);
    rx_valid = 1'b0;
    check("t5a_done", done_b, 1'b1);
    check("t5a_resolved", resolved_b, 48'h0102_0304_0506);
    vc = 0;
    repeat (20) begin
      if (mac_valid_b) vc++;
      @(negedge clk);
    end
    check("t5a_no_retx", vc, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

endmodule
